// File: rtl/seq_det_pkg.sv
// Shared defaults, mode encodings and width helper for the parameterised
// serial pattern detector.
package seq_det_pkg;

    localparam int unsigned DEF_MAX_LEN = 8;
    localparam int unsigned DEF_CNT_W   = 8;

    localparam logic MODE_MEALY = 1'b0;
    localparam logic MODE_MOORE = 1'b1;
    localparam logic OVL_OFF    = 1'b0;
    localparam logic OVL_ON     = 1'b1;

    // Bits needed to hold a pattern length in 0..max_len.
    function automatic int unsigned LEN_W(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating up-counter: counts inc pulses and sticks at all-ones.
module seq_det_sat_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/seq_det_param.sv
// Runtime-configurable serial pattern detector with overlap / non-overlap
// matching, Mealy or Moore pulse timing and a saturating match counter.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int unsigned MAX_LEN = DEF_MAX_LEN,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_seq,
    input  logic                      in_valid,
    input  logic                      cfg_load,
    input  logic [MAX_LEN-1:0]        cfg_pat,
    input  logic [LEN_W(MAX_LEN)-1:0] cfg_len,
    input  logic                      cfg_overlap,
    input  logic                      cfg_moore,
    output logic                      det_out,
    output logic [CNT_W-1:0]          match_cnt,
    output logic                      cfg_err
);

    localparam int unsigned LW = LEN_W(MAX_LEN);
    localparam int unsigned WW = MAX_LEN + 1;

    logic [MAX_LEN-1:0] pat_q,  pat_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      len_q,  len_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               ovl_q,  ovl_d;
    logic               moore_q, moore_d;
    logic               err_q,  err_d;
    logic               det_q,  det_d;

    logic [WW-1:0]      window_c;
    logic [WW-1:0]      mask_c;
    logic               fill_ok_c;
    logic               len_legal_c;
    logic               hit_c;

    // Compare the newest len_q bits (history plus the incoming bit) to the pattern.
    always_comb begin
        mask_c = '0;
        for (int i = 0; i < int'(WW); i++) begin
            mask_c[i] = (i < int'(len_q));
        end
        window_c    = {hist_q, in_seq};
        fill_ok_c   = (int'(fill_q) + 1) >= int'(len_q);
        len_legal_c = (int'(cfg_len) >= 2) && (int'(cfg_len) <= int'(MAX_LEN));
        hit_c       = rst && in_valid && !cfg_load && !err_q && fill_ok_c
                      && (((window_c ^ {1'b0, pat_q}) & mask_c) == '0);
    end

    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        moore_d = moore_q;
        err_d   = err_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        det_d   = hit_c;
        if (cfg_load) begin
            // A load takes priority over a coincident data bit, which is dropped.
            pat_d   = cfg_pat;
            len_d   = cfg_len;
            ovl_d   = cfg_overlap;
            moore_d = cfg_moore;
            err_d   = !len_legal_c;
            hist_d  = '0;
            fill_d  = '0;
            det_d   = 1'b0;
        end else if (in_valid) begin
            hist_d = window_c[MAX_LEN-1:0];
            if (hit_c && (ovl_q == OVL_OFF)) begin
                fill_d = '0;
            end else if (int'(fill_q) < int'(MAX_LEN)) begin
                fill_d = fill_q + LW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pat_q   <= '0;
            len_q   <= '0;
            ovl_q   <= OVL_ON;
            moore_q <= MODE_MEALY;
            err_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            det_q   <= 1'b0;
        end else begin
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            moore_q <= moore_d;
            err_q   <= err_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            det_q   <= det_d;
        end
    end

    // Moore pulses come from the register; Mealy pulses are the live hit.
    assign det_out = rst && ((moore_q == MODE_MOORE) ? det_q : hit_c);
    assign cfg_err = err_q;

    seq_det_sat_cnt #(
        .W (CNT_W)
    ) u_cnt (
        .clk (clk),
        .rst (rst),
        .inc (hit_c),
        .cnt (match_cnt)
    );

endmodule

// File: tb/tb_seq_det_param.sv
// Scoreboard bench for seq_det_param: a bit-queue reference model predicts
// each cycle's outputs for a default instance and a 2-bit-counter instance.
module tb_seq_det_param;

    logic       clk;
    logic       rst;
    logic       in_seq;
    logic       in_valid;
    logic       cfg_load;
    logic [7:0] cfg_pat;
    logic [3:0] cfg_len;
    logic       cfg_overlap;
    logic       cfg_moore;

    logic       det_a, err_a, det_b, err_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    seq_det_param #(.MAX_LEN(8), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore),
        .det_out(det_a), .match_cnt(cnt_a), .cfg_err(err_a)
    );

    seq_det_param #(.MAX_LEN(8), .CNT_W(2)) dut_b (
        .clk(clk), .rst(rst), .in_seq(in_seq), .in_valid(in_valid),
        .cfg_load(cfg_load), .cfg_pat(cfg_pat), .cfg_len(cfg_len),
        .cfg_overlap(cfg_overlap), .cfg_moore(cfg_moore),
        .det_out(det_b), .match_cnt(cnt_b), .cfg_err(err_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       det;
        logic       err;
        logic [7:0] cnt_a;
        logic [1:0] cnt_b;
        int         cyc;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;
    int   cyc        = 0;

    // Reference model: configuration plus the list of bits seen since the last clear.
    logic [7:0] m_pat;
    int         m_len;
    logic       m_ovl, m_moore, m_err, m_prev;
    bit         m_bits[$];
    int         m_cnt_a, m_cnt_b;

    logic [7:0] c_pat;
    logic [3:0] c_len;
    logic       c_ovl, c_moore;

    task automatic model_reset();
        m_pat = '0; m_len = 0; m_ovl = 1'b1; m_moore = 1'b0; m_err = 1'b1;
        m_prev = 1'b0; m_bits.delete(); m_cnt_a = 0; m_cnt_b = 0;
    endtask

    function automatic logic model_hit(input logic r, input logic v, input logic b, input logic ld);
        bit w[$];
        if (!r || !v || ld || m_err) return 1'b0;
        w = m_bits;
        w.push_back(b);
        if (w.size() < m_len) return 1'b0;
        for (int k = 0; k < m_len; k++) begin
            if (w[w.size() - m_len + k] != m_pat[m_len - 1 - k]) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Drive one cycle, push the expected outputs for it, then advance the model.
    task automatic tick(input logic r, input logic v, input logic b, input logic ld);
        exp_t e;
        logic hit;
        rst = r; in_valid = v; in_seq = b; cfg_load = ld;
        if (ld) begin
            cfg_pat = c_pat; cfg_len = c_len; cfg_overlap = c_ovl; cfg_moore = c_moore;
        end else begin
            cfg_pat = 8'($urandom); cfg_len = 4'($urandom);
            cfg_overlap = 1'($urandom); cfg_moore = 1'($urandom);
        end
        hit     = model_hit(r, v, b, ld);
        e.det   = r ? (m_moore ? m_prev : hit) : 1'b0;
        e.err   = m_err;
        e.cnt_a = 8'(m_cnt_a);
        e.cnt_b = 2'(m_cnt_b);
        e.cyc   = cyc;
        sb.push_back(e);
        if (!r) begin
            model_reset();
        end else if (ld) begin
            m_pat = c_pat; m_len = int'(c_len); m_ovl = c_ovl; m_moore = c_moore;
            m_err = !((m_len >= 2) && (m_len <= 8));
            m_bits.delete(); m_prev = 1'b0;
        end else begin
            m_prev = hit;
            if (v) begin
                if (hit && !m_ovl) begin
                    m_bits.delete();
                end else begin
                    m_bits.push_back(b);
                    if (m_bits.size() > 8) void'(m_bits.pop_front());
                end
            end
            if (hit) begin
                if (m_cnt_a < 255) m_cnt_a++;
                if (m_cnt_b < 3) m_cnt_b++;
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic load(input logic [7:0] p, input logic [3:0] l, input logic o, input logic m);
        c_pat = p; c_len = l; c_ovl = o; c_moore = m;
        tick(1'b1, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic send(input logic [15:0] bits, input int n);
        logic [15:0] w;
        w = bits;
        for (int i = n - 1; i >= 0; i--) tick(1'b1, 1'b1, w[i], 1'b0);
    endtask

    task automatic chk(input string nm, input int c, input logic [7:0] act, input logic [7:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", nm, c, act, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a sample mid-cycle; compare with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("det_out_a",   e.cyc, {7'd0, det_a}, {7'd0, e.det});
                chk("det_out_b",   e.cyc, {7'd0, det_b}, {7'd0, e.det});
                chk("cfg_err_a",   e.cyc, {7'd0, err_a}, {7'd0, e.err});
                chk("cfg_err_b",   e.cyc, {7'd0, err_b}, {7'd0, e.err});
                chk("match_cnt_a", e.cyc, cnt_a, e.cnt_a);
                chk("match_cnt_b", e.cyc, {6'd0, cnt_b}, {6'd0, e.cnt_b});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0; in_seq = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        cfg_pat = '0; cfg_len = '0; cfg_overlap = 1'b0; cfg_moore = 1'b0;
        c_pat = '0; c_len = '0; c_ovl = 1'b0; c_moore = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        tick(1'b1, 1'b1, 1'b1, 1'b0);

        // Overlapping Mealy, then non-overlapping, on 1,0,1,1,0,1,1,0.
        load(8'b10110, 4'd5, 1'b1, 1'b0);
        send(16'b10110110, 8);
        load(8'b10110, 4'd5, 1'b0, 1'b0);
        send(16'b10110110, 8);

        // Overlapping Moore with a valid gap right after the first match.
        load(8'b10110, 4'd5, 1'b1, 1'b1);
        send(16'b10110, 5);
        tick(1'b1, 1'b0, 1'b1, 1'b0);
        send(16'b110, 3);
        tick(1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        // Illegal lengths block detection; a legal load restores it.
        load(8'hFF, 4'd1, 1'b1, 1'b0);
        send(16'hFF, 8);
        load(8'hFF, 4'd9, 1'b1, 1'b0);
        send(16'hFF, 8);
        load(8'b11, 4'd2, 1'b1, 1'b0);
        send(16'b11, 2);

        // Drive the 2-bit counter into saturation, then reset mid-pattern.
        send(16'b1111111, 7);
        load(8'b10110, 4'd5, 1'b1, 1'b0);
        send(16'b101, 3);
        tick(1'b0, 1'b1, 1'b1, 1'b0);
        send(16'b10, 2);

        // Moore pulse pending when reset arrives must not show.
        load(8'b10110, 4'd5, 1'b1, 1'b1);
        send(16'b10110, 5);
        tick(1'b0, 1'b0, 1'b0, 1'b0);

        // Load coincides with the last pattern bit: bit dropped, history cleared.
        load(8'b10110, 4'd5, 1'b1, 1'b0);
        send(16'b1011, 4);
        c_pat = 8'b10110; c_len = 4'd5; c_ovl = 1'b1; c_moore = 1'b0;
        tick(1'b1, 1'b1, 1'b0, 1'b1);
        send(16'b0110, 4);
        send(16'b10110, 5);

        // Randomised traffic with occasional loads and resets.
        for (int n = 0; n < 4000; n++) begin
            logic r, v, b, ld;
            r  = ($urandom_range(0, 299) != 0);
            ld = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 9) < 8);
            b  = 1'($urandom);
            if (ld) begin
                c_pat   = 8'($urandom);
                c_len   = 4'($urandom_range(0, 10));
                c_ovl   = 1'($urandom);
                c_moore = 1'($urandom);
            end
            tick(r, v, b, ld);
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain: %0d predictions never checked, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
